// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing a single-port register file between requesters A and B,
// with per-requester locking for read-modify-write sequences and a bounded lock hold time.
module regfile_access_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              prio_r, prio_nxt_s;      // 1'b0 favours A, 1'b1 favours B
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              grant_a_s, grant_b_s;
  logic              a_rsp_valid_r, b_rsp_valid_r;
  logic [DATA_W-1:0] rsp_data_r;

  // Grant selection: lock owner only, otherwise sole requester or round-robin winner
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    case (state_r)
      ST_ARB: begin
        if (a_valid && b_valid) begin
          if (prio_r) begin
            grant_b_s = 1'b1;
          end else begin
            grant_a_s = 1'b1;
          end
        end else begin
          grant_a_s = a_valid;
          grant_b_s = b_valid;
        end
      end
      ST_LOCK_A: grant_a_s = a_valid;
      ST_LOCK_B: grant_b_s = b_valid;
      default: begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    endcase
  end

  // Next state, priority and lock hold counter
  always_comb begin
    state_nxt_s = state_r;
    prio_nxt_s  = prio_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_ARB: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (grant_a_s) begin
          if (a_lock) begin
            state_nxt_s = ST_LOCK_A;
          end else begin
            prio_nxt_s = 1'b1;
          end
        end else if (grant_b_s) begin
          if (b_lock) begin
            state_nxt_s = ST_LOCK_B;
          end else begin
            prio_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_LOCK_A: begin
        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        // Timeout releases even when the owner re-locks in the final cycle
        if ((grant_a_s && !a_lock) || (cnt_r == CNT_LAST)) begin
          state_nxt_s = ST_ARB;
          prio_nxt_s  = 1'b1;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_LOCK_A;
        end
      end
      ST_LOCK_B: begin
        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if ((grant_b_s && !b_lock) || (cnt_r == CNT_LAST)) begin
          state_nxt_s = ST_ARB;
          prio_nxt_s  = 1'b0;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_LOCK_B;
        end
      end
      default: begin
        state_nxt_s = ST_ARB;
        prio_nxt_s  = 1'b0;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Register-file port mux driven by the granted requester
  always_comb begin
    if (grant_a_s) begin
      rf_we    = a_we;
      rf_addr  = a_addr;
      rf_wdata = a_wdata;
    end else if (grant_b_s) begin
      rf_we    = b_we;
      rf_addr  = b_addr;
      rf_wdata = b_wdata;
    end else begin
      rf_we    = 1'b0;
      rf_addr  = {ADDR_W{1'b0}};
      rf_wdata = {DATA_W{1'b0}};
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_ARB;
      prio_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      prio_r  <= prio_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Response capture: write data echoes back, reads sample the file before its write edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rsp_valid_r <= 1'b0;
      b_rsp_valid_r <= 1'b0;
      rsp_data_r    <= {DATA_W{1'b0}};
    end else begin
      a_rsp_valid_r <= grant_a_s;
      b_rsp_valid_r <= grant_b_s;
      if (grant_a_s) begin
        rsp_data_r <= a_we ? a_wdata : rf_rdata;
      end else if (grant_b_s) begin
        rsp_data_r <= b_we ? b_wdata : rf_rdata;
      end else begin
        rsp_data_r <= rsp_data_r;
      end
    end
  end

  assign a_ready     = grant_a_s;
  assign b_ready     = grant_b_s;
  assign a_rsp_valid = a_rsp_valid_r;
  assign b_rsp_valid = b_rsp_valid_r;
  assign rsp_data    = rsp_data_r;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of ownership, turn-taking and register contents.
module tb_regfile_access_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 6;
  localparam int LOCK_MAX = 8;

  logic clk, rst_n;
  logic a_valid, a_ready, a_we, a_lock, a_rsp_valid;
  logic b_valid, b_ready, b_we, b_lock, b_rsp_valid;
  logic [ADDR_W-1:0] a_addr, b_addr, rf_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata, rsp_data, rf_wdata, rf_rdata;
  logic rf_we;

  logic [DATA_W-1:0] rf_mem  [64];
  logic [DATA_W-1:0] ref_mem [64];
  logic preload;

  int checks = 0;
  int errors = 0;

  // Model state: owner 0=none 1=A 2=B, turn = who wins a tie
  int owner, held, turn, last_g;
  logic exp_av, exp_bv;
  logic [DATA_W-1:0] exp_data;
  logic last_b_ready;
  int stalls;

  regfile_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_lock(a_lock),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_lock(b_lock),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid),
    .rsp_data(rsp_data), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(int i);
    if (i == 0) return 32'd5;
    if (i == 1) return 32'd7;
    return i * 32'h0101_0101;
  endfunction

  // Register file attached to the arbiter
  assign rf_rdata = rf_mem[rf_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) rf_mem[i] <= init_val(i);
    end else if (rf_we) begin
      rf_mem[rf_addr] <= rf_wdata;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant();
    if (owner == 1) return a_valid ? 1 : 0;
    if (owner == 2) return b_valid ? 2 : 0;
    if (a_valid && b_valid) return turn;
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  task automatic model_update(int g);
    logic lk;
    lk = 1'b0;
    exp_av = (g == 1);
    exp_bv = (g == 2);
    if (g == 1) begin
      exp_data = a_we ? a_wdata : ref_mem[a_addr];
      if (a_we) ref_mem[a_addr] = a_wdata;
      lk = a_lock;
    end else if (g == 2) begin
      exp_data = b_we ? b_wdata : ref_mem[b_addr];
      if (b_we) ref_mem[b_addr] = b_wdata;
      lk = b_lock;
    end
    if (owner != 0) begin
      held++;
      if ((g == owner && !lk) || held == LOCK_MAX) begin
        turn  = 3 - owner;
        owner = 0;
      end
    end else if (g != 0) begin
      if (lk) begin
        owner = g;
        held  = 0;
      end else begin
        turn = 3 - g;
      end
    end
    last_g = g;
  endtask

  task automatic model_reset();
    owner = 0; held = 0; turn = 1; last_g = 0;
    exp_av = 1'b0; exp_bv = 1'b0; exp_data = '0;
  endtask

  // One clock: compare combinational and registered outputs, then advance the model
  task automatic step();
    int g;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ew;
    logic ewe;
    #1;
    g = model_grant();
    ea = (g == 1) ? a_addr : (g == 2) ? b_addr : '0;
    ew = (g == 1) ? a_wdata : (g == 2) ? b_wdata : '0;
    ewe = (g == 1) ? a_we : (g == 2) ? b_we : 1'b0;
    chk("a_ready", a_ready, g == 1);
    chk("b_ready", b_ready, g == 2);
    chk("one_ready", a_ready & b_ready, 1'b0);
    chk("rf_we", rf_we, ewe);
    chk("rf_addr", rf_addr, ea);
    chk("rf_wdata", rf_wdata, ew);
    chk("a_rsp_valid", a_rsp_valid, exp_av);
    chk("b_rsp_valid", b_rsp_valid, exp_bv);
    chk("rsp_data", rsp_data, exp_data);
    last_b_ready = b_ready;
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic drive_a(logic v, logic we, logic lk, logic [ADDR_W-1:0] ad, logic [DATA_W-1:0] wd);
    a_valid = v; a_we = we; a_lock = lk; a_addr = ad; a_wdata = wd;
  endtask

  task automatic drive_b(logic v, logic we, logic lk, logic [ADDR_W-1:0] ad, logic [DATA_W-1:0] wd);
    b_valid = v; b_we = we; b_lock = lk; b_addr = ad; b_wdata = wd;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_a_rsp", a_rsp_valid, 1'b0);
    chk("rst_b_rsp", b_rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_addr", rf_addr, 6'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    return ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b0;
    preload = 1'b1;
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    model_reset();
    @(posedge clk);
    #1;
    preload = 1'b0;
    do_reset();

    // Single reads of the preloaded registers
    drive_a(1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    step();
    drive_a(1'b1, 1'b0, 1'b0, 6'd1, 32'd0);
    step();
    chk("t1_rsp7", rsp_data, 32'd7);
    drive_a(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    step();

    // Contention from a fresh reset alternates starting with A
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 1'b0, 1'b0, 6'(i), 32'd0);
      drive_b(1'b1, 1'b0, 1'b0, 6'(i + 8), 32'd0);
      #1;
      chk("t2_alt_a", a_ready, (i % 2) == 0);
      step();
    end

    // Locked read-modify-write by A while B waits to read the result
    drive_b(1'b1, 1'b0, 1'b0, 6'd2, 32'd0);
    drive_a(1'b1, 1'b0, 1'b1, 6'd0, 32'd0);
    step();
    drive_a(1'b1, 1'b0, 1'b1, 6'd1, 32'd0);
    step();
    drive_a(1'b1, 1'b1, 1'b0, 6'd2, 32'd12);
    step();
    drive_a(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    step();
    chk("t3_b_rd2", rsp_data, 32'd12);
    drive_b(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    step();

    // Lock timeout: A locks then goes idle, B must wait exactly LOCK_MAX cycles
    drive_a(1'b1, 1'b0, 1'b1, 6'd3, 32'd0);
    drive_b(1'b1, 1'b0, 1'b0, 6'd4, 32'd0);
    step();
    drive_a(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_b_ready) break;
      stalls++;
    end
    chk("t4_stalls", stalls, LOCK_MAX);
    drive_b(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    step();

    // Write to the top index followed immediately by a read of it
    drive_b(1'b1, 1'b1, 1'b0, 6'd63, 32'hDEAD_BEEF);
    step();
    drive_b(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    drive_a(1'b1, 1'b0, 1'b0, 6'd63, 32'd0);
    step();
    chk("t5_a_rsp", a_rsp_valid, 1'b1);
    chk("t5_data", rsp_data, 32'hDEAD_BEEF);
    drive_a(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    step();

    // Reset while B holds a lock with its response in flight
    drive_b(1'b1, 1'b0, 1'b1, 6'd5, 32'd0);
    step();
    chk("t6_pending", b_rsp_valid, 1'b1);
    do_reset();
    drive_a(1'b1, 1'b0, 1'b0, 6'd6, 32'd0);
    drive_b(1'b1, 1'b0, 1'b0, 6'd7, 32'd0);
    #1;
    chk("t6_a_first", a_ready, 1'b1);
    step();
    step();

    // Randomized traffic; a requester keeps its request stable until granted
    for (int n = 0; n < 400; n++) begin
      if (!(a_valid && last_g != 1))
        drive_a($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, pick_addr(), $urandom);
      if (!(b_valid && last_g != 2))
        drive_b($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, pick_addr(), $urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares the single-port 64 x 32 register file between two requesters, A (datapath) and B (debug/preload loader).
- Arbitrates per cycle with round-robin priority and drives the register-file address, write-enable and write-data.
- Returns registered read data one cycle after grant.
- Supports a lock so one requester can hold the port across a read-modify-write sequence, with a timeout that stops a lock from starving the other side.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 6, register index width (64 entries).
- LOCK_MAX, 8, maximum consecutive cycles a lock may hold the port; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  A request present.
- a_ready  out  1  A granted this cycle.
- a_we  in  1  A request is a write (1) or a read (0).
- a_lock  in  1  keep the port for A after this transaction.
- a_addr  in  ADDR_W  A register index.
- a_wdata  in  DATA_W  A write data.
- a_rsp_valid  out  1  A response valid.
- b_valid, b_ready, b_we, b_lock, b_addr, b_wdata, b_rsp_valid: same widths and meanings for B.
- rsp_data  out  DATA_W  response data, shared by A and B.
- rf_we  out  1  register-file write enable.
- rf_addr  out  ADDR_W  register-file index.
- rf_wdata  out  DATA_W  register-file write data.
- rf_rdata  in  DATA_W  register-file combinational read data at rf_addr.

Behaviour:

Reset (asynchronous, rst_n=0):
- state=ARB, prio=A, lock_cnt=0.
- a_rsp_valid=0, b_rsp_valid=0, rsp_data=0.
- With no grant: a_ready=b_ready=0, rf_we=0, rf_addr=0, rf_wdata=0.

Handshake:
- A transfer occurs in a cycle where X_valid=1 and X_ready=1.
- The requester holds valid, we, lock, addr and wdata stable until ready.
- X_ready is combinational from state, prio and the valids.
- At most one ready is high per cycle.

Datapath (combinational in the grant cycle):
- rf_addr = granted addr.
- rf_we = granted we.
- rf_wdata = granted wdata.
- With no grant, all three are 0.

Response:
- Cycle N+1 after a grant in cycle N: X_rsp_valid=1 for exactly one cycle.
- rsp_data = rf_rdata sampled at the edge for a read, or the written wdata for a write.
- Otherwise both rsp_valid are 0 and rsp_data holds its last value.
- A read in the cycle after a write to the same index returns the new value; the register file writes at that edge.

States:
- ARB:
  - Grant the sole valid requester.
  - If both are valid, grant prio.
  - After a grant to X with lock=0: prio=other(X).
  - After a grant to X with lock=1: go to LOCK_X, lock_cnt=0, prio unchanged.
- LOCK_A / LOCK_B:
  - Only the owner can be granted; the other side's ready=0.
  - lock_cnt increments every cycle spent in the lock state, whether or not the owner is valid.
  - Owner grant with lock=1: stay.
  - Owner grant with lock=0: go to ARB, prio=other.
  - Timeout: if lock_cnt==LOCK_MAX-1 at a clock edge and the owner is not releasing, go to ARB with prio=other. This applies even if the owner was granted with lock=1 that cycle; that transaction still completes normally.
  - Owner not valid: no grant, rf_we=0 (stall).

Boundary conditions:
- Both valid while in LOCK_A: only A is served; B waits, with b_ready=0.
- Reset mid-lock: returns immediately to ARB/prio=A. Responses in flight are dropped, and rsp_valid deasserts asynchronously.
- Lock asserted on a read is legal.
- Writes to any index, including 0 and 63, pass through unmodified.

Test Plan:
1. Reset and single reads:
   - Stimulus: release rst_n; register file preloaded reg0=5, reg1=7; A reads 0, then reads 1.
   - Response: a_ready=1 in each request cycle; a_rsp_valid next cycle with rsp_data=5, then 7; b_rsp_valid stays 0.
2. Contention, round-robin:
   - Stimulus: A and B both hold valid for 4 cycles.
   - Response: grants alternate A,B,A,B starting with A after reset; no cycle has both ready high.
3. Locked read-modify-write:
   - Stimulus: A reads 0 with lock=1 (rsp=5); A reads 1 with lock=1 (rsp=7); A writes reg2=12 with lock=0; B valid throughout.
   - Response: b_ready=0 for those three cycles; B granted on the next cycle; a B read of 2 returns 12.
4. Lock timeout:
   - Stimulus: LOCK_MAX=8; A locks, then drops valid; B valid.
   - Response: no grants while in LOCK_A; ARB is re-entered after lock_cnt reaches 7, and B is granted on the next cycle.
5. Write-then-read hazard:
   - Stimulus: B writes reg63=0xDEADBEEF; the next cycle A reads 63.
   - Response: b_rsp_valid with rsp_data=0xDEADBEEF, then a_rsp_valid with rsp_data=0xDEADBEEF.
6. Reset mid-lock:
   - Stimulus: assert rst_n=0 asynchronously, mid-cycle, while in LOCK_B with a response pending.
   - Response: rsp_valid=0 immediately; after release, both valid, so A is granted first.
